ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: ps2_clk glitch-filter depth in clk samples.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65000: idle clk cycles that abort a partial frame.
REQ-003 SHALL have port clk  input  1  system clock; the single clock domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock, asynchronous.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data, asynchronous.
REQ-007 SHALL have port key  output  4  currently held game key (key_* code), registered.
REQ-008 SHALL have port scan_code  output  8  last valid received byte, registered.
REQ-009 SHALL have port scan_valid  output  1  one-cycle pulse when scan_code updates.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-011 SHALL synchronise ps2_clk and ps2_data through two flops each before any use.
REQ-012 SHALL update filtered ps2_clk only after FILTER_LEN consecutive equal synchronised samples; a falling edge of the filtered clock is a bit strobe.
REQ-013 Frame SHALL be 11 bits, LSB first: start=0, 8 data bits, odd parity, stop=1.
REQ-014 SHALL accept a frame only if start=0, stop=1 and the 9 bits data+parity contain an odd number of ones; otherwise pulse frame_err and discard it.
REQ-015 SHALL pulse scan_valid and load scan_code exactly 1 clk after the strobe that samples the stop bit.
REQ-016 SHALL clear the bit counter and shift register, without pulsing frame_err, when TIMEOUT_CYC cycles pass with no strobe mid-frame.
REQ-017 Decode FSM states: IDLE, EXT (after 0xE0), BRK (after 0xF0), EXT_BRK (after 0xE0 then 0xF0).
REQ-018 Transitions on each scan_valid: IDLE: 0xE0->EXT, 0xF0->BRK, other->make, stay IDLE; EXT: 0xF0->EXT_BRK, other->extended make, ->IDLE; BRK and EXT_BRK: any byte->break, ->IDLE.
REQ-019 Mapping, normal: 0x1D->key_W, 0x1C->key_A, 0x1B->key_S, 0x23->key_D, 0x29->key_SPACE, 0x24->key_E; extended: 0x75->key_W, 0x6B->key_A, 0x72->key_S, 0x74->key_D; all other codes are unmapped and ignored.
REQ-020 A mapped make SHALL set key to its code 1 clk after scan_valid, replacing any held key (last-pressed wins); a typematic repeat leaves key unchanged.
REQ-021 A mapped break SHALL set key to key_NONE only if it matches the held key; otherwise key is unchanged.
REQ-022 A frame error SHALL return the decode FSM to IDLE and leave key unchanged.

Reset
REQ-023 While rst=0 at a clk edge: key=key_NONE, scan_code=0x00, scan_valid=0, frame_err=0, FSM=IDLE, bit counter, shift register and timeout counter cleared, filter and synchroniser flops set to 1 (bus idle).
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; the first frame that starts after release SHALL be received normally.

Structure
REQ-025 key_NONE=4'h0, key_W=4'h1, key_A=4'h2, key_S=4'h3, key_D=4'h4, key_SPACE=4'h5 and key_E=4'h6 SHALL be defined in vga_pkg and used by all key producers and consumers.
REQ-026 Scan-code constants and the decode FSM state typedef SHALL be local to the module.
REQ-027 Synchronisation, filtering, framing, parity and timeout SHALL be a sub-module ps2_rx with outputs data[7:0], data_valid and err; ps2_key_decoder instantiates it and contains the decode FSM.

Verification
REQ-028 Send frame 0x23 (parity 0, ~12.5 kHz PS/2 clock) -> scan_valid pulses once with scan_code=0x23, and key=4'h4 one clk later.
REQ-029 Send 0x1C, 0x23, then 0xF0 0x1C -> key sequence 2, 4, 4 (the break of a non-held key is ignored); then 0xF0 0x23 -> key=0.
REQ-030 Send 0xE0 0x6B, then 0xE0 0xF0 0x6B -> key=2, then key=0.
REQ-031 Send 0x1D with a bad parity bit -> frame_err pulses once, scan_valid stays 0, key unchanged; the next good 0x1D sets key=1.
REQ-032 Inject 4-clk glitches on ps2_clk, and separately stop a frame after 5 bits for more than TIMEOUT_CYC -> no strobes from the glitches, no frame_err, and the next full frame 0x29 gives key=5.
REQ-033 Drive rst=0 for one clk mid-frame while key=4 -> key=0 the next cycle, and the following full frame 0x24 gives key=6.

Source files
------------

// File: rtl/vga_pkg.sv
// Key codes shared by every producer and consumer of game-key state.
package vga_pkg;

  localparam logic [3:0] key_NONE  = 4'h0;
  localparam logic [3:0] key_W     = 4'h1;
  localparam logic [3:0] key_A     = 4'h2;
  localparam logic [3:0] key_S     = 4'h3;
  localparam logic [3:0] key_D     = 4'h4;
  localparam logic [3:0] key_SPACE = 4'h5;
  localparam logic [3:0] key_E     = 4'h6;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: synchronisers, clock glitch filter, 11-bit framing,
// odd-parity check and partial-frame timeout.
module ps2_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          filt_done;
  logic          strobe;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] idle_cnt;

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample;
  // a 1->0 flip is the bit strobe, taken in the same cycle.
  assign filt_done = (clk_sync[1] != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign strobe    = filt_done && filt_clk;

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync   <= '1;
      dat_sync   <= '1;
      filt_clk   <= 1'b1;
      filt_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      idle_cnt   <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      dat_sync   <= {dat_sync[0], ps2_data};
      data_valid <= 1'b0;
      err        <= 1'b0;

      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_done) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end

      if (strobe) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          // shreg[0]=start, shreg[8:1]=data, shreg[9]=parity; dat_sync is stop
          bit_cnt <= '0;
          shreg   <= '0;
          if (!shreg[0] && dat_sync[1] && (^shreg[9:1])) begin
            data       <= shreg[8:1];
            data_valid <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end else begin
          shreg   <= {dat_sync[1], shreg[9:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
          bit_cnt  <= '0;
          shreg    <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: receives scan codes and tracks the held game key
// through make/break/extended prefix decoding.
module ps2_key_decoder
  import vga_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_E     = 8'h24;
  localparam logic [7:0] SC_X_UP  = 8'h75;
  localparam logic [7:0] SC_X_LT  = 8'h6B;
  localparam logic [7:0] SC_X_DN  = 8'h72;
  localparam logic [7:0] SC_X_RT  = 8'h74;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t     state;
  logic [3:0] code_key;

  function automatic logic [3:0] map_code(input logic [7:0] code, input logic ext);
    logic [3:0] k;
    k = key_NONE;
    if (!ext) begin
      case (code)
        SC_W:     k = key_W;
        SC_A:     k = key_A;
        SC_S:     k = key_S;
        SC_D:     k = key_D;
        SC_SPACE: k = key_SPACE;
        SC_E:     k = key_E;
        default:  k = key_NONE;
      endcase
    end else begin
      case (code)
        SC_X_UP: k = key_W;
        SC_X_LT: k = key_A;
        SC_X_DN: k = key_S;
        SC_X_RT: k = key_D;
        default: k = key_NONE;
      endcase
    end
    return k;
  endfunction

  ps2_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data       (scan_code),
    .data_valid (scan_valid),
    .err        (frame_err)
  );

  always_comb begin
    code_key = map_code(scan_code, (state == EXT) || (state == EXT_BRK));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      key   <= key_NONE;
    end else if (frame_err) begin
      state <= IDLE;
    end else if (scan_valid) begin
      unique case (state)
        IDLE: begin
          if (scan_code == SC_EXT) begin
            state <= EXT;
          end else if (scan_code == SC_BRK) begin
            state <= BRK;
          end else if (code_key != key_NONE) begin
            key <= code_key;
          end
        end
        EXT: begin
          if (scan_code == SC_BRK) begin
            state <= EXT_BRK;
          end else begin
            state <= IDLE;
            if (code_key != key_NONE) key <= code_key;
          end
        end
        BRK, EXT_BRK: begin
          state <= IDLE;
          if (code_key != key_NONE && code_key == key) key <= key_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed and random PS/2 frames
// against a prefix-flag reference model of the key tracker.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] key;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  ps2_key_decoder #(
    .FILTER_LEN  (8),
    .TIMEOUT_CYC (300)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key        (key),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_err  (frame_err)
  );

  always #500 clk = ~clk;   // 1 MHz system clock; 80 clk per PS/2 bit = 12.5 kHz

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    logic [3:0] key;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int   norm_map[int];
  int   ext_map[int];
  bit   m_ext = 0;
  bit   m_brk = 0;
  logic [3:0] m_key = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lookup(input logic [7:0] b, input bit ext);
    if (ext) return ext_map.exists(int'(b)) ? 4'(ext_map[int'(b)]) : 4'h0;
    return norm_map.exists(int'(b)) ? 4'(norm_map[int'(b)]) : 4'h0;
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit bad);
    exp_t e;
    logic [3:0] k;
    if (bad) begin
      m_ext = 0; m_brk = 0;
      e.is_err = 1; e.code = 8'h00; e.key = m_key;
    end else begin
      if (m_brk) begin
        k = lookup(b, m_ext);
        if (k != 4'h0 && k == m_key) m_key = 4'h0;
        m_ext = 0; m_brk = 0;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else if (b == 8'hE0 && !m_ext) begin
        m_ext = 1;
      end else begin
        k = lookup(b, m_ext);
        if (k != 4'h0) m_key = k;
        m_ext = 0;
      end
      e.is_err = 0; e.code = b; e.key = m_key;
    end
    q.push_back(e);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Drives the first nbits bits of a frame; bad flips the parity bit.
  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_clk(20);
      ps2_clk = 1'b0;
      wait_clk(40);
      ps2_clk = 1'b1;
      wait_clk(20);
    end
    ps2_data = 1'b1;
    wait_clk(100);
  endtask

  task automatic send(input logic [7:0] b, input bit bad);
    model_byte(b, bad);
    send_frame(b, bad, 11);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && (scan_valid || frame_err)) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {scan_code, 6'h0, scan_valid, frame_err}, 32'h0);
        end else begin
          e = q.pop_front();
          chk("frame_err", frame_err, e.is_err);
          chk("scan_valid", scan_valid, !e.is_err);
          if (!e.is_err) chk("scan_code", scan_code, e.code);
          @(negedge clk);
          chk("key", key, e.key);
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    int         sel;
    norm_map[8'h1D] = 1; norm_map[8'h1C] = 2; norm_map[8'h1B] = 3;
    norm_map[8'h23] = 4; norm_map[8'h29] = 5; norm_map[8'h24] = 6;
    ext_map[8'h75] = 1;  ext_map[8'h6B] = 2;  ext_map[8'h72] = 3; ext_map[8'h74] = 4;

    rst = 1'b0;
    wait_clk(5);
    @(negedge clk);
    chk("reset_key", key, 4'h0);
    chk("reset_scan_code", scan_code, 8'h00);
    chk("reset_scan_valid", scan_valid, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    rst = 1'b1;
    wait_clk(20);

    send(8'h23, 0);                                   // key=4

    // reset pulse mid-frame while key=4
    send_frame(8'h1B, 0, 4);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_key", key, 4'h0);
    chk("midreset_scan_code", scan_code, 8'h00);
    rst = 1'b1;
    m_key = 4'h0; m_ext = 0; m_brk = 0;
    wait_clk(100);
    send(8'h24, 0);                                   // key=6

    send(8'h1C, 0); send(8'h23, 0); send(8'hF0, 0); send(8'h1C, 0);
    send(8'hF0, 0); send(8'h23, 0);
    send(8'hE0, 0); send(8'h6B, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h6B, 0);
    send(8'h1D, 1); send(8'h1D, 0);
    send(8'hE0, 0); send(8'h1D, 1); send(8'h1B, 0);  // error drops the E0 prefix

    for (int i = 0; i < 10; i++) begin                // glitches while idle
      ps2_clk = 1'b0;
      wait_clk(4);
      ps2_clk = 1'b1;
      wait_clk(30);
    end
    send_frame(8'h55, 0, 5);                          // abandoned partial frame
    wait_clk(400);
    send(8'h29, 0);                                   // key=5

    for (int i = 0; i < 30; i++) begin
      sel = int'($urandom_range(0, 15));
      case (sel)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = 8'(norm_map.size() + $urandom_range(0, 255));
        5:       b = 8'h1D;
        6:       b = 8'h1C;
        7:       b = 8'h1B;
        8:       b = 8'h23;
        9:       b = 8'h29;
        10:      b = 8'h24;
        11:      b = 8'h75;
        12:      b = 8'h6B;
        13:      b = 8'h72;
        default: b = 8'h74;
      endcase
      send(b, $urandom_range(0, 9) == 0);
    end

    wait_clk(300);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
